// File: rtl/pkt_capture_ctrl_pkg.sv
// Shared types and defaults for the packet capture controller.
package pktctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 15;
  localparam int DATA_WIDTH_DEF = 36;
  localparam int DROP_CNT_WIDTH = 16;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pkt_capture_ctrl_if.sv
// Bundle of the capture controller's sample, readback, config/status and SRAM signals.
// Handshakes: a transfer happens in a cycle where valid (in_valid / rd_req) and
// ready (in_ready / rd_ready) are both high; ready never depends on valid and an
// in_valid seen while in_ready is low is a dropped sample, not a stall.
interface pkt_capture_ctrl_if
  import pktctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                      cfg_start;
  logic                      cfg_abort;
  logic [ADDR_WIDTH-1:0]     cfg_post_len;
  logic                      trig_in;
  logic                      in_valid;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      in_ready;
  logic                      rd_req;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic                      rd_ready;
  logic                      rd_valid;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      busy;
  logic                      done;
  logic                      wrapped;
  logic [ADDR_WIDTH-1:0]     trig_addr;
  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  logic                      mem_ceb;
  logic                      mem_web;
  logic [ADDR_WIDTH-1:0]     mem_a;
  logic [DATA_WIDTH-1:0]     mem_d;
  logic [DATA_WIDTH-1:0]     mem_q;
  state_e                    state_dbg;

  // Controller side.
  modport master (
    input  cfg_start, cfg_abort, cfg_post_len, trig_in, in_valid, in_data,
           rd_req, rd_addr, mem_q,
    output in_ready, rd_ready, rd_valid, rd_data, busy, done, wrapped,
           trig_addr, wr_ptr, drop_cnt, mem_ceb, mem_web, mem_a, mem_d, state_dbg
  );

  // Host / sample source / SRAM side.
  modport slave (
    output cfg_start, cfg_abort, cfg_post_len, trig_in, in_valid, in_data,
           rd_req, rd_addr, mem_q,
    input  in_ready, rd_ready, rd_valid, rd_data, busy, done, wrapped,
           trig_addr, wr_ptr, drop_cnt, mem_ceb, mem_web, mem_a, mem_d, state_dbg
  );

endinterface

// File: rtl/pkt_capture_ctrl.sv
// Circular-buffer capture controller in front of a single-port capture SRAM.
// Optional saturating dropped-sample counter: define PKTCTRL_DROP_CNT_EN.
module pkt_capture_ctrl
  import pktctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RSTN,
  pkt_capture_ctrl_if.master bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
  logic                  wrapped_q, wrapped_d;
  logic                  mem_ceb_q, mem_ceb_d;
  logic                  mem_web_q, mem_web_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [DATA_WIDTH-1:0] mem_d_q, mem_d_d;
  logic                  rd_issue_q, rd_valid_q;
  logic                  in_ready, rd_ready, wr_acc, rd_acc;

  // Capture and readback own the port in disjoint states, so they never collide.
  assign in_ready = (state_q == ARMED) || (state_q == POST);
  assign rd_ready = (state_q == IDLE) || (state_q == DONE);
  assign wr_acc   = bus.in_valid & in_ready;
  assign rd_acc   = bus.rd_req & rd_ready;

  // State register and capture bookkeeping.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      wrapped_q   <= wrapped_d;
    end
  end

  // Next-state logic; abort beats start, start beats per-state behaviour.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    wrapped_d   = wrapped_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (&wr_ptr_q) wrapped_d = 1'b1;
    end

    if (bus.cfg_abort) begin
      state_d    = IDLE;
      post_cnt_d = '0;
    end else if (bus.cfg_start) begin
      state_d   = ARMED;
      wr_ptr_d  = '0;
      wrapped_d = 1'b0;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (bus.trig_in) begin
            // An accepted trigger-cycle sample lands at wr_ptr, so both cases agree.
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = bus.cfg_post_len;
            if (!wr_acc && (bus.cfg_post_len == '0)) state_d = DONE;
            else                                     state_d = POST;
          end
        end
        POST: begin
          if (post_cnt_q == '0) begin
            state_d = DONE;
          end else if (wr_acc) begin
            post_cnt_d = post_cnt_q - ADDR_WIDTH'(1);
            if (post_cnt_q == ADDR_WIDTH'(1)) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM command: one registered access per accepted sample or read.
  always_comb begin
    mem_ceb_d = 1'b1;
    mem_web_d = 1'b1;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    if (wr_acc) begin
      mem_ceb_d = 1'b0;
      mem_web_d = 1'b0;
      mem_a_d   = wr_ptr_q;
      mem_d_d   = bus.in_data;
    end else if (rd_acc) begin
      mem_ceb_d = 1'b0;
      mem_a_d   = bus.rd_addr;
    end
  end

  // SRAM command registers and the two-stage read-valid pipeline.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem_ceb_q  <= 1'b1;
      mem_web_q  <= 1'b1;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      rd_issue_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_ceb_q  <= mem_ceb_d;
      mem_web_q  <= mem_web_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      rd_issue_q <= rd_acc;
      rd_valid_q <= rd_issue_q;
    end
  end

`ifdef PKTCTRL_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of cycles where a sample arrived with nowhere to go.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.cfg_start)
      drop_cnt_d = '0;
    else if (bus.in_valid && !in_ready && !(&drop_cnt_q))
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
  end

  // Drop counter register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.rd_ready  = rd_ready;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = bus.mem_q;
  assign bus.busy      = in_ready;
  assign bus.done      = (state_q == DONE);
  assign bus.wrapped   = wrapped_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.wr_ptr    = wr_ptr_q;
  assign bus.mem_ceb   = mem_ceb_q;
  assign bus.mem_web   = mem_web_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_d     = mem_d_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pkt_capture_ctrl.sv
// Self-checking bench for pkt_capture_ctrl with a behavioural 32768x36 SRAM.
// Exercises PKTCTRL_DROP_CNT_EN behaviour when that macro is defined.
module tb_pkt_capture_ctrl;
  import pktctrl_pkg::*;

  localparam int AW = 15;
  localparam int DW = 36;

  typedef struct {
    logic          trig;
    logic [DW-1:0] data;
    logic          exp_done;
    logic          exp_busy;
    logic [AW-1:0] exp_wr_ptr;
  } vec_t;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;

  pkt_capture_ctrl_if bus ();

  pkt_capture_ctrl dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (bus.mem_ceb === 1'b0) begin
      if (bus.mem_web === 1'b0) sram[bus.mem_a] <= bus.mem_d;
      else                      bus.mem_q <= sram[bus.mem_a];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [AW+DW-1:0] exp_q[$];     // expected {addr, data} SRAM writes
  logic [DW-1:0]    rd_exp_q[$];  // expected readback words
  logic [DW-1:0]    ref_mem [0:(1<<AW)-1];
  logic [AW-1:0]    exp_wr_ptr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Pop expected writes / reads when the DUT produces them.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (bus.mem_ceb === 1'b0 && bus.mem_web === 1'b0) begin
        if (exp_q.size() == 0) check("unexpected_write", {bus.mem_a, bus.mem_d}, '0);
        else check("sram_write", {bus.mem_a, bus.mem_d}, exp_q.pop_front());
      end
      if (bus.rd_valid === 1'b1) begin
        if (rd_exp_q.size() == 0) check("unexpected_rd_valid", bus.rd_data, '0);
        else check("rd_data", bus.rd_data, rd_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic trig, input logic acc);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.trig_in  = trig;
    if (acc) begin
      exp_q.push_back({exp_wr_ptr, d});
      ref_mem[exp_wr_ptr] = d;
      exp_wr_ptr = exp_wr_ptr + 1'b1;
    end
    cycle();
    bus.in_valid = 1'b0;
    bus.trig_in  = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] plen);
    bus.cfg_start    = 1'b1;
    bus.cfg_post_len = plen;
    cycle();
    bus.cfg_start = 1'b0;
    exp_wr_ptr    = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, bus.state_dbg, IDLE);
    check({tag, "_mem_ceb"}, bus.mem_ceb, 1'b1);
    check({tag, "_mem_web"}, bus.mem_web, 1'b1);
    check({tag, "_mem_a"}, bus.mem_a, '0);
    check({tag, "_mem_d"}, bus.mem_d, '0);
    check({tag, "_wr_ptr"}, bus.wr_ptr, '0);
    check({tag, "_trig_addr"}, bus.trig_addr, '0);
    check({tag, "_drop_cnt"}, bus.drop_cnt, '0);
    check({tag, "_wrapped"}, bus.wrapped, 1'b0);
    check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_rd_ready"}, bus.rd_ready, 1'b1);
  endtask

  vec_t vecs [14];

  // ---------------- test sequence ----------------
  initial begin
    logic [DW-1:0] rnd;
    logic [AW-1:0] a;

    bus.cfg_start = 0; bus.cfg_abort = 0; bus.cfg_post_len = '0; bus.trig_in = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.rd_req = 0; bus.rd_addr = '0;

    for (int i = 0; i < 14; i++) begin
      vecs[i].trig       = (i == 10);
      vecs[i].data       = DW'(i);
      vecs[i].exp_done   = (i == 13);
      vecs[i].exp_busy   = (i != 13);
      vecs[i].exp_wr_ptr = AW'(i + 1);
    end

    repeat (3) cycle();
    check_reset_values("rst");
    RSTN = 1'b1;
    cycle();

    // Basic capture: 10 pre-trigger, trigger sample 0xA, 3 post samples.
    start(AW'(3));
    check("armed_busy", bus.busy, 1'b1);
    check("armed_rd_ready", bus.rd_ready, 1'b0);
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].data, vecs[i].trig, 1'b1);
      check($sformatf("vec%0d_done", i), bus.done, vecs[i].exp_done);
      check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_wr_ptr", i), bus.wr_ptr, vecs[i].exp_wr_ptr);
    end
    check("cap_trig_addr", bus.trig_addr, AW'(10));
    check("cap_wrapped", bus.wrapped, 1'b0);
    send(DW'(36'hBAD), 1'b0, 1'b0);  // dropped in DONE, must not write
    cycle();
    check("cap_writes_drained", exp_q.size(), 0);

    // Readback of 10..12 pipelined.
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = AW'(10 + k);
        rd_exp_q.push_back(ref_mem[10 + k]);
      end else begin
        bus.rd_req = 1'b0;
      end
      cycle();
      check($sformatf("rd_valid_k%0d", k), bus.rd_valid, (k >= 1 && k <= 3));
      check($sformatf("rd_web_k%0d", k), bus.mem_web, 1'b1);
    end
    cycle();

    // Depth stress: 2^15+5 samples before the trigger.
    start(AW'(0));
    check("restart_keeps_trig_addr", bus.trig_addr, AW'(10));
    for (int i = 0; i < (1 << AW) + 5; i++) begin
      rnd = {4'($urandom_range(0, 15)), 32'($urandom)};
      send(rnd, 1'b0, 1'b1);
    end
    check("depth_wrapped", bus.wrapped, 1'b1);
    check("depth_wr_ptr", bus.wr_ptr, AW'(5));
    send(DW'(36'h7_1234_5678), 1'b1, 1'b1);  // trigger with sample, post_len 0
    check("depth_trig_addr", bus.trig_addr, AW'(5));
    check("depth_post0_not_done", bus.done, 1'b0);
    cycle();
    check("depth_post0_done", bus.done, 1'b1);
    check("depth_final_wr_ptr", bus.wr_ptr, AW'(6));
    for (int k = 0; k < 8; k++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      bus.rd_req  = 1'b1;
      bus.rd_addr = a;
      rd_exp_q.push_back(ref_mem[a]);
      cycle();
    end
    bus.rd_req = 1'b0;
    repeat (3) cycle();

    // post_len 0 with trigger in a cycle without a sample.
    start(AW'(0));
    for (int i = 0; i < 3; i++) send(DW'(36'h100 + i), 1'b0, 1'b1);
    bus.trig_in = 1'b1;
    cycle();
    bus.trig_in = 1'b0;
    check("nosmp_done", bus.done, 1'b1);
    check("nosmp_trig_addr", bus.trig_addr, AW'(3));
    send(DW'(36'h200), 1'b1, 1'b0);  // trigger ignored and sample dropped in DONE
    cycle();
    check("nosmp_wr_ptr", bus.wr_ptr, AW'(3));
    check("nosmp_trig_ignored", bus.trig_addr, AW'(3));

    // Abort during POST, then start+abort together, then restart in ARMED.
    start(AW'(5));
    send(DW'(36'h300), 1'b0, 1'b1);
    send(DW'(36'h301), 1'b1, 1'b1);
    check("post_state", bus.state_dbg, POST);
    bus.cfg_abort = 1'b1;
    cycle();
    bus.cfg_abort = 1'b0;
    check("abort_state", bus.state_dbg, IDLE);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b0);
    check("abort_mem_ceb", bus.mem_ceb, 1'b1);
    bus.cfg_start = 1'b1;
    bus.cfg_abort = 1'b1;
    cycle();
    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    check("start_abort_state", bus.state_dbg, IDLE);
    start(AW'(4));
    send(DW'(36'h400), 1'b0, 1'b1);
    send(DW'(36'h401), 1'b0, 1'b1);
    bus.cfg_start = 1'b1;
    cycle();
    bus.cfg_start = 1'b0;
    exp_wr_ptr = '0;
    check("restart_state", bus.state_dbg, ARMED);
    check("restart_wr_ptr", bus.wr_ptr, '0);
    check("restart_wrapped", bus.wrapped, 1'b0);
    send(DW'(36'h500), 1'b0, 1'b1);
    send(DW'(36'h501), 1'b1, 1'b1);

    // Asynchronous reset mid-capture.
    #6;
    RSTN = 1'b0;
    #1;
    check_reset_values("async_rst");
    cycle();
    RSTN = 1'b1;
    exp_wr_ptr = '0;
    cycle();

`ifdef PKTCTRL_DROP_CNT_EN
    bus.in_valid = 1'b1;
    repeat (65534) cycle();
    check("drop_cnt_fffe", bus.drop_cnt, 16'hFFFE);
    repeat (6) cycle();
    check("drop_cnt_sat", bus.drop_cnt, 16'hFFFF);
    bus.in_valid = 1'b0;
    start(AW'(1));
    check("drop_cnt_clear", bus.drop_cnt, 16'h0);
`else
    bus.in_valid = 1'b1;
    repeat (20) cycle();
    bus.in_valid = 1'b0;
    check("drop_cnt_tied", bus.drop_cnt, 16'h0);
`endif

    repeat (3) cycle();
    check("final_write_queue", exp_q.size(), 0);
    check("final_read_queue", rd_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
